// File: rtl/sp_ram_load_ctrl_pkg.sv
// Shared definitions for the RAM-path blocks: default widths and the
// load-controller state encoding (IDLE=0 .. CHECK=4).
package sp_ram_load_ctrl_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_CHECK  = 3'd4
  } state_e;

endpackage

// File: rtl/sp_dist_ram_256x8.sv
// Single-port distributed RAM: synchronous write, asynchronous read.
// Ports: clk_in, write_en, address_in, data_in (write side),
//        data_out (combinational read of address_in).
module sp_dist_ram_256x8
  import sp_ram_load_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_in,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk_in) begin
    if (write_en) mem_q[address_in] <= data_in;
  end

  assign data_out = mem_q[address_in];

endmodule

// File: rtl/sp_ram_load_ctrl.sv
// Load controller: accepts a stream of length_in bytes (valid/ready),
// writes them to consecutive RAM addresses starting at base_addr_in
// (wrapping), then reads the region back and compares an additive
// checksum. done_out pulses on match; error_out is sticky on mismatch
// or illegal length and is cleared by the next accepted start.
// Ports:
//   clk_in, rst_n_in                 clock, async active-low reset
//   start_in, base_addr_in, length_in job request (sampled in IDLE)
//   s_valid_in, s_data_in, s_ready_out upstream byte stream
//   ram_write_en_out, ram_address_out, ram_data_out, ram_data_in  RAM port
//   busy_out, done_out, error_out    status
module sp_ram_load_ctrl
  import sp_ram_load_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] base_addr_in,
  input  logic [ADDR_W:0]   length_in,
  input  logic              s_valid_in,
  input  logic [DATA_W-1:0] s_data_in,
  output logic              s_ready_out,
  output logic              ram_write_en_out,
  output logic [ADDR_W-1:0] ram_address_out,
  output logic [DATA_W-1:0] ram_data_out,
  input  logic [DATA_W-1:0] ram_data_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              error_out
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  // Counts accepted bytes in LOAD, then read cycles in VERIFY.
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   wsum_q, wsum_d;
  logic [DATA_W-1:0]   rsum_q, rsum_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept;
  logic                len_ok;
  logic [ADDR_W:0]     len_m1;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      base_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      wsum_q <= '0;
      rsum_q <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      wsum_q <= wsum_d;
      rsum_q <= rsum_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wsum_d  = wsum_q;
    rsum_d  = rsum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;
    accept  = s_valid_in & (state_q == ST_LOAD);
    len_ok  = (length_in != '0) && (length_in <= MAX_LEN);
    len_m1  = len_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          if (len_ok) begin
            base_d  = base_addr_in;
            len_d   = length_in;
            cnt_d   = '0;
            wsum_d  = '0;
            rsum_d  = '0;
            err_d   = 1'b0;
            state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          // Write is registered: presented in the cycle after the accept.
          we_d   = 1'b1;
          addr_d = base_q + cnt_q[ADDR_W-1:0];
          data_d = s_data_in;
          wsum_d = wsum_q + s_data_in;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == len_m1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Last write is on the bus now; line up the first read address.
        addr_d  = base_q;
        cnt_d   = '0;
        state_d = ST_VERIFY;
      end
      ST_VERIFY: begin
        rsum_d = rsum_q + ram_data_in;
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == len_m1) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (wsum_q == rsum_q) done_d = 1'b1;
        else                  err_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_ready_out      = (state_q == ST_LOAD);
  assign busy_out         = (state_q != ST_IDLE);
  assign ram_write_en_out = we_q;
  assign ram_address_out  = addr_q;
  assign ram_data_out     = data_q;
  assign done_out         = done_q;
  assign error_out        = err_q;

endmodule

// File: tb/tb_sp_ram_load_ctrl.sv
// Self-checking bench for sp_ram_load_ctrl with a real distributed RAM.
// Expected RAM writes are queued when bytes are issued; a negedge monitor
// pops and compares every write the controller presents and counts done
// pulses. Job-level status is checked by the stimulus after each job.
module tb_sp_ram_load_ctrl;
  import sp_ram_load_ctrl_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, dut_we, busy, done, err;
  logic [AW-1:0] dut_addr;
  logic [DW-1:0] dut_wdata, ram_rdata;

  // Bench-side write port used to corrupt RAM contents mid-job.
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [DW-1:0] tb_wdata = '0;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;

  assign ram_we    = dut_we | tb_we;
  assign ram_addr  = tb_we ? tb_addr : dut_addr;
  assign ram_wdata = tb_we ? tb_wdata : dut_wdata;

  always #5 clk = ~clk;

  sp_ram_load_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .base_addr_in(base),
    .length_in(len), .s_valid_in(s_valid), .s_data_in(s_data),
    .s_ready_out(s_ready), .ram_write_en_out(dut_we),
    .ram_address_out(dut_addr), .ram_data_out(dut_wdata),
    .ram_data_in(ram_rdata), .busy_out(busy), .done_out(done),
    .error_out(err)
  );

  sp_dist_ram_256x8 #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
    .clk_in(clk), .write_en(ram_we), .address_in(ram_addr),
    .data_in(ram_wdata), .data_out(ram_rdata)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t            exp_q[$];
  wr_t            mon_e;
  int             nchk = 0;
  int             nerr = 0;
  int             done_cnt = 0;
  logic [7:0][DW-1:0] pay;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented write must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (dut_we) begin
        if (exp_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", dut_addr, dut_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(dut_addr), 32'(mon_e.addr));
          check("wr_data", 32'(dut_wdata), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic load_job(input logic [AW-1:0] b, input int n, input bit gaps,
                          input bit corrupt, input int exp_done, input bit exp_err);
    int d0;
    int t;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; base = b; len = n[AW:0];
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("ready_in_load", 32'(s_ready), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = pay[i];
      exp_q.push_back(wr_t'{addr: AW'(int'(b) + i), data: pay[i]});
      @(negedge clk);
    end
    s_valid = 1'b0;
    if (corrupt) begin
      // Now in DRAIN; next negedge is the first VERIFY cycle. Overwrite
      // base+2 so the read-back checksum cannot match.
      @(negedge clk);
      tb_we = 1'b1; tb_addr = b + 8'd2; tb_wdata = 8'h00;
      @(negedge clk);
      tb_we = 1'b0;
    end
    t = 0;
    while (busy && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      nchk++;
      nerr++;
      $display("FAIL job_timeout: busy still 1 after %0d cycles, required 0", t);
    end
    repeat (2) @(negedge clk);
    check("done_pulses", 32'(done_cnt - d0), 32'(exp_done));
    check("error_after_job", 32'(err), 32'(exp_err));
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic bad_len(input logic [AW:0] l);
    @(negedge clk);
    start = 1'b1; base = 8'h40; len = l;
    @(negedge clk);
    start = 1'b0;
    check("badlen_error", 32'(err), 32'd1);
    check("badlen_busy", 32'(busy), 32'd0);
    check("badlen_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    check("badlen_error_sticky", 32'(err), 32'd1);
    check("badlen_busy_later", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_we"}, 32'(dut_we), 32'd0);
    check({tag, "_addr"}, 32'(dut_addr), 32'd0);
    check({tag, "_wdata"}, 32'(dut_wdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(err), 32'd0);
  endtask

  initial begin
    pay = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Basic job, checksum 11+22+33+44 = 0xAA.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    load_job(8'h10, 4, 1'b0, 1'b0, 1, 1'b0);
    check("mem10", 32'(u_ram.mem_q[8'h10]), 32'h11);
    check("mem13", 32'(u_ram.mem_q[8'h13]), 32'h44);

    // Illegal lengths: 0 and 257.
    bad_len(9'd0);
    bad_len(9'd257);

    // Top of address space, no wrap; also clears the sticky error.
    pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3; pay[3] = 8'hA4;
    load_job(8'hFC, 4, 1'b0, 1'b0, 1, 1'b0);
    check("memFF", 32'(u_ram.mem_q[8'hFF]), 32'hA4);

    // Wrapping region FE,FF,00,01.
    pay[0] = 8'h05; pay[1] = 8'h06; pay[2] = 8'h07; pay[3] = 8'h08;
    load_job(8'hFE, 4, 1'b0, 1'b0, 1, 1'b0);
    check("mem00", 32'(u_ram.mem_q[8'h00]), 32'h07);
    check("mem01", 32'(u_ram.mem_q[8'h01]), 32'h08);

    // Valid gaps 1,0,0,1,... over 8 bytes.
    for (int i = 0; i < 8; i++) pay[i] = DW'(8'hC0 + i);
    load_job(8'h20, 8, 1'b1, 1'b0, 1, 1'b0);

    // Corrupted read-back -> error, no done.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    load_job(8'h30, 4, 1'b0, 1'b1, 0, 1'b1);

    // Reset after 3 of 8 bytes.
    @(negedge clk);
    start = 1'b1; base = 8'h50; len = 9'd8;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(8'h70 + i);
      exp_q.push_back(wr_t'{addr: AW'(8'h50 + i), data: DW'(8'h70 + i)});
      @(negedge clk);
    end
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midjob_reset");
    check("mem52_kept", 32'(u_ram.mem_q[8'h52]), 32'h72);
    @(negedge clk);
    rst_n = 1'b1;
    pay[0] = 8'h9A; pay[1] = 8'hBC;
    load_job(8'h60, 2, 1'b0, 1'b0, 1, 1'b0);

    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", nchk, nerr);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sp_ram_load_ctrl.md
SP_RAM_LOAD_CTRL -- requirements
Module: sp_ram_load_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have port clk_in  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n_in  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_in  input  1  begin a load job; sampled only in IDLE.
REQ-006 SHALL have port base_addr_in  input  ADDR_W  first RAM address of the job.
REQ-007 SHALL have port length_in  input  ADDR_W+1  byte count; legal range 1..2^ADDR_W.
REQ-008 SHALL have port s_valid_in  input  1  upstream byte valid.
REQ-009 SHALL have port s_data_in  input  DATA_W  upstream byte.
REQ-010 SHALL have port s_ready_out  output  1  byte accepted when s_valid_in and s_ready_out are both high at a clock edge.
REQ-011 SHALL have port ram_write_en_out  output  1  RAM write enable (drives write_en).
REQ-012 SHALL have port ram_address_out  output  ADDR_W  RAM address (drives address_in).
REQ-013 SHALL have port ram_data_out  output  DATA_W  RAM write data (drives data_in).
REQ-014 SHALL have port ram_data_in  input  DATA_W  RAM asynchronous read data (from data_out).
REQ-015 SHALL have port busy_out  output  1  high in every state except IDLE.
REQ-016 SHALL have port done_out  output  1  one-cycle pulse: job finished, checksum matched.
REQ-017 SHALL have port error_out  output  1  sticky: bad length or checksum mismatch; cleared by next accepted start.

Function
REQ-018 SHALL implement states IDLE, LOAD, DRAIN, VERIFY, CHECK.
REQ-019 SHALL, in IDLE with start_in=1 and length_in in 1..2^ADDR_W, latch base/length, clear checksum and error_out, and go to LOAD at that edge.
REQ-020 SHALL, in IDLE with start_in=1 and length_in of 0 or >2^ADDR_W, stay in IDLE, set error_out, and issue no RAM writes.
REQ-021 SHALL drive s_ready_out=1 only in LOAD; each accepted byte is added mod 2^DATA_W to the write checksum.
REQ-022 SHALL register writes: a byte accepted at edge k drives ram_write_en_out=1, ram_address_out=base+i (mod 2^ADDR_W), ram_data_out=byte during the cycle after edge k; ram_write_en_out=0 in any cycle with no preceding accept.
REQ-023 SHALL go LOAD->DRAIN on the edge accepting byte length-1; DRAIN presents that last write and goes to VERIFY next edge.
REQ-024 SHALL, in VERIFY, hold ram_write_en_out=0, step ram_address_out base..base+length-1 (wrapping) one per cycle, add ram_data_in into the read checksum each cycle, and go to CHECK after length cycles.
REQ-025 SHALL, in CHECK, compare checksums, return to IDLE next edge, pulse done_out for the first IDLE cycle on match, or set error_out on mismatch with no done_out.
REQ-026 SHALL ignore start_in while busy_out=1.
REQ-027 SHALL tolerate s_valid_in gaps in LOAD indefinitely with no timeout.

Reset
REQ-028 SHALL, on rst_n_in=0, immediately enter IDLE and set s_ready_out, ram_write_en_out, busy_out, done_out, error_out to 0, and ram_address_out, ram_data_out, both checksums, and counters to 0.
REQ-029 SHALL, on reset mid-job, abandon the job; any RAM bytes already written stay as written, and no done_out is issued.

Structure
REQ-030 SHALL take state encodings (IDLE=0..CHECK=4) and default widths from a shared package/header used by the RAM-path blocks.
REQ-031 SHALL be a single module with no sub-modules; the bench instantiates sp_dist_ram_256x8 as the RAM.

Verification
REQ-032 SHALL cover: base=0x10, len=4, bytes 11,22,33,44 back-to-back -> writes at 0x10..0x13, checksum 0xAA, done_out pulses once, error_out=0.
REQ-033 SHALL cover: base=0xFC, len=4 -> writes at FC,FD,FE,FF,00,...? No: addresses FC,FD,FE,FF; base=0xFE len=4 -> FE,FF,00,01 with wrap, done_out pulses.
REQ-034 SHALL cover: length_in=0 and length_in=257 -> error_out=1, busy_out=0, zero RAM writes.
REQ-035 SHALL cover: s_valid_in toggling 1,0,0,1... for len=8 -> exactly 8 writes, one per accept, no write in gap cycles.
REQ-036 SHALL cover: bench corrupts RAM byte at base+2 during DRAIN/VERIFY -> error_out=1, no done_out pulse.
REQ-037 SHALL cover: rst_n_in low after 3 of 8 bytes -> outputs at reset values immediately, new start with len=2 completes with done_out.
